// File: rtl/latch_mem_pkg.sv
// Shared constants and helpers for the latch memory read/write ports.
package latch_mem_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 16;
  // Widest wordline the shared decoder can produce; ports must keep DEPTH below this.
  localparam int OH_AW  = 12;
  localparam int OH_MAX = 1 << OH_AW;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [OH_MAX-1:0] onehot(input int unsigned a);
    logic [OH_MAX-1:0] v;
    v = '0;
    if (a < OH_MAX) v[a[OH_AW-1:0]] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/latch_read_tree.sv
// Combinational AND-OR row select, built as an alternating NAND/NOR tree.
// DEPTH is padded to the next power of two with zero rows.
module latch_read_tree import latch_mem_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [DEPTH-1:0]       rwl,
  input  logic [DEPTH*WIDTH-1:0] mem,
  output logic [WIDTH-1:0]       rdata
);
  localparam int L = clog2(DEPTH);
  localparam int P = 1 << L;

  // Heap-ordered nodes: root at 1, leaves at P..2P-1; leaves are active-low.
  logic [2*P-1:1][WIDTH-1:0] nd;

  genvar i;
  for (i = 0; i < P; i++) begin : g_leaf
    if (i < DEPTH) begin : g_row
      assign nd[P+i] = ~(mem[i*WIDTH +: WIDTH] & {WIDTH{rwl[i]}});
    end else begin : g_pad
      assign nd[P+i] = '1;
    end
  end

  // Odd heights combine active-low children (NAND), even heights active-high (NOR).
  for (i = 1; i < P; i++) begin : g_node
    localparam int H = L - (clog2(i + 1) - 1);
    if (H % 2 == 1) begin : g_nand
      assign nd[i] = ~(nd[2*i] & nd[2*i+1]);
    end else begin : g_nor
      assign nd[i] = ~(nd[2*i] | nd[2*i+1]);
    end
  end

  if (L % 2 == 1) begin : g_out_hi
    assign rdata = nd[1];
  end else begin : g_out_lo
    assign rdata = ~nd[1];
  end
endmodule

// File: rtl/latch_mem_read_port.sv
// Two-stage pipelined read port: registered one-hot wordline, then registered data.
// Optional out-of-range check enabled by `define LATCH_RD_ADDR_CHK_EN.
module latch_mem_read_port import latch_mem_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RD_REQ,
  input  logic [AW-1:0]          RD_ADDR,
  output logic                   RD_RDY,
  output logic [DEPTH-1:0]       RWL,
  input  logic [DEPTH*WIDTH-1:0] MemoryLatch,
  output logic [WIDTH-1:0]       DOUT,
  output logic                   DOUT_VLD,
  input  logic                   DOUT_RDY,
  output logic                   RD_ERR
);
  logic              s1_vld, advance, accept;
  logic [DEPTH-1:0]  rwl_q;
  logic [OH_MAX-1:0] oh;
  logic              oh_unused;
  logic [WIDTH-1:0]  rdata, dout_q;
  logic              dout_vld_q;

  assign advance = !dout_vld_q || DOUT_RDY;
  assign RD_RDY  = !s1_vld || advance;
  assign accept  = RD_REQ && RD_RDY;

  // Out-of-range addresses decode above DEPTH-1 and leave the wordline empty.
  assign oh        = onehot(32'(RD_ADDR));
  assign oh_unused = ^oh[OH_MAX-1:DEPTH];

  // Stage 1 holds the decoded wordline; it is cleared whenever the stage empties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld <= 1'b0;
      rwl_q  <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      rwl_q  <= oh[DEPTH-1:0];
    end else if (advance) begin
      s1_vld <= 1'b0;
      rwl_q  <= '0;
    end
  end

  latch_read_tree #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tree (
    .rwl   (rwl_q),
    .mem   (MemoryLatch),
    .rdata (rdata)
  );

  // DOUT only loads with a real word so it keeps its last value across idle cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (advance) begin
      dout_vld_q <= s1_vld;
      if (s1_vld) dout_q <= rdata;
    end
  end

`ifdef LATCH_RD_ADDR_CHK_EN
  logic err_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                              err_q <= 1'b0;
    else if (accept && ({1'b0, RD_ADDR} >= (AW+1)'(DEPTH))) err_q <= 1'b1;
  end
  assign RD_ERR = err_q;
`else
  assign RD_ERR = 1'b0;
`endif

  assign RWL      = rwl_q;
  assign DOUT     = dout_q;
  assign DOUT_VLD = dout_vld_q;
endmodule

// File: tb/tb_latch_mem_read_port.sv
// Bench for latch_mem_read_port: a 16-row and a 12-row port checked against a
// transaction-level model every cycle, plus directed literal expectations.
module tb_latch_mem_read_port;
`ifdef LATCH_RD_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0]       req = '0, rdy_in = 2'b11;
  logic [1:0][3:0]  addr = '0;
  logic [1:0]       rd_rdy, vld, err;
  logic [1:0][15:0] dout;
  logic [15:0]      rwl16;
  logic [11:0]      rwl12;
  logic [16*16-1:0] mem16;
  logic [12*16-1:0] mem12;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  latch_mem_read_port #(.WIDTH(16), .DEPTH(16)) u_d16 (
    .CLK(clk), .RST(rst), .RD_REQ(req[0]), .RD_ADDR(addr[0]), .RD_RDY(rd_rdy[0]),
    .RWL(rwl16), .MemoryLatch(mem16), .DOUT(dout[0]), .DOUT_VLD(vld[0]),
    .DOUT_RDY(rdy_in[0]), .RD_ERR(err[0]));

  latch_mem_read_port #(.WIDTH(16), .DEPTH(12)) u_d12 (
    .CLK(clk), .RST(rst), .RD_REQ(req[1]), .RD_ADDR(addr[1]), .RD_RDY(rd_rdy[1]),
    .RWL(rwl12), .MemoryLatch(mem12), .DOUT(dout[1]), .DOUT_VLD(vld[1]),
    .DOUT_RDY(rdy_in[1]), .RD_ERR(err[1]));

  function automatic int dep(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic logic [15:0] row(input int d, input int a);
    if (a >= dep(d)) return 16'h0;
    return (d == 0) ? mem16[a*16 +: 16] : mem12[a*16 +: 16];
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: queue of accepted addresses not yet handed off; mv marks that the
  // head of the queue is the word currently presented on DOUT.
  int          mq [2][$];
  bit          mv [2] = '{0, 0};
  logic [15:0] md [2] = '{16'h0, 16'h0};
  bit          me [2] = '{0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mq[d].delete();
        mv[d] = 0; md[d] = 16'h0; me[d] = 0;
      end else begin
        bit adv, rdy_e, acc;
        adv   = !mv[d] || rdy_in[d];
        rdy_e = (mq[d].size() <= (mv[d] ? 1 : 0)) || adv;
        acc   = req[d] && rdy_e;
        if (mv[d] && rdy_in[d]) begin
          void'(mq[d].pop_front());
          mv[d] = 0;
        end
        if (adv && mq[d].size() > 0) begin
          mv[d] = 1;
          md[d] = row(d, mq[d][0]);
        end
        if (acc) begin
          mq[d].push_back(int'(addr[d]));
          if (CHK && int'(addr[d]) >= dep(d)) me[d] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int idx, a;
      logic [15:0] er, ar;
      bit erdy;
      idx = mv[d] ? 1 : 0;
      er  = 16'h0;
      if (mq[d].size() > idx) begin
        a = mq[d][idx];
        if (a < dep(d)) er = 16'(1 << a);
      end
      erdy = (mq[d].size() <= idx) || !mv[d] || rdy_in[d];
      ar   = (d == 0) ? rwl16 : {4'h0, rwl12};
      chk("rd_rdy", d, 32'(rd_rdy[d]), 32'(erdy));
      chk("dout_vld", d, 32'(vld[d]), 32'(mv[d]));
      chk("dout", d, 32'(dout[d]), 32'(md[d]));
      chk("rwl", d, 32'(ar), 32'(er));
      chk("rd_err", d, 32'(err[d]), 32'(me[d]));
    end
  end

  task automatic go(input bit r0, input int a0, input bit r1, input int a1, input bit y);
    #1;
    req[0] = r0; addr[0] = a0[3:0];
    req[1] = r1; addr[1] = a1[3:0];
    rdy_in = {y, y};
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) mem16[r*16 +: 16] = 16'hA500 + 16'(r);
    for (int r = 0; r < 12; r++) mem12[r*16 +: 16] = 16'hC000 + 16'(r);

    @(negedge clk);
    chk("reset_rdy", 0, 32'(rd_rdy[0]), 32'd1);
    chk("reset_vld", 0, 32'(vld[0]), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset mid-read
    go(1, 3, 1, 3, 1);
    chk("mid_rwl", 0, 32'(rwl16), 32'h0008);
    #1 rst = 1'b1; req = '0;
    #1;
    chk("rst_rwl", 0, 32'(rwl16), 32'h0);
    chk("rst_rwl", 1, 32'(rwl12), 32'h0);
    chk("rst_vld", 0, 32'(vld), 32'h0);
    chk("rst_dout", 0, 32'(dout[0]), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 0, 32'(rd_rdy), 32'h3);

    // Back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      go(1, i, 1, i % 12, 1);
      if (i >= 1) chk("stream", 0, 32'(dout[0]), 32'hA500 + 32'(i - 1));
    end
    go(0, 0, 0, 0, 1);
    chk("stream_last", 0, 32'(dout[0]), 32'hA50F);
    go(0, 0, 0, 0, 1);

    // Backpressure
    go(1, 5, 0, 0, 1);
    go(1, 6, 0, 0, 1);
    chk("bp_first", 0, 32'(dout[0]), 32'hA505);
    for (int k = 0; k < 3; k++) begin
      go(1, 7, 0, 0, 0);
      chk("bp_hold", 0, 32'(dout[0]), 32'hA505);
      chk("bp_rwl", 0, 32'(rwl16), 32'h0040);
      chk("bp_rdy", 0, 32'(rd_rdy[0]), 32'd0);
    end
    go(1, 7, 0, 0, 1);
    chk("bp_second", 0, 32'(dout[0]), 32'hA506);
    go(0, 0, 0, 0, 1);
    chk("bp_third", 0, 32'(dout[0]), 32'hA507);

    // Idle
    for (int k = 0; k < 4; k++) begin
      go(0, 0, 0, 0, 1);
      chk("idle_rwl", 0, 32'(rwl16), 32'h0);
      chk("idle_vld", 0, 32'(vld[0]), 32'd0);
      chk("idle_dout", 0, 32'(dout[0]), 32'hA507);
    end

    // Non-power-of-2 depth and out-of-range address
    go(0, 0, 1, 11, 1);
    go(0, 0, 0, 0, 1);
    chk("np2_row11", 1, 32'(dout[1]), 32'hC00B);
    chk("np2_err0", 1, 32'(err[1]), 32'd0);
    go(0, 0, 1, 13, 1);
    chk("oor_rwl", 1, 32'(rwl12), 32'h0);
    go(0, 0, 0, 0, 1);
    chk("oor_dout", 1, 32'(dout[1]), 32'h0);
    chk("oor_vld", 1, 32'(vld[1]), 32'd1);
    chk("oor_err", 1, 32'(err[1]), 32'(CHK));
    go(0, 0, 1, 2, 1);
    go(0, 0, 0, 0, 1);
    chk("legal_after", 1, 32'(dout[1]), 32'hC002);
    chk("err_sticky", 1, 32'(err[1]), 32'(CHK));

    // Randomised traffic with a reset pulse in the middle
    for (int n = 0; n < 800; n++) begin
      #1;
      req    = 2'($urandom_range(0, 3));
      addr   = 8'($urandom);
      rdy_in = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      rst    = (n == 400);
      @(negedge clk);
    end
    #1 rst = 1'b0; req = '0; rdy_in = 2'b11;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
